// File: rtl/regfile_pkg.sv
// Shared defaults and the write-port priority search used by the forwarding muxes.
// Pure types/functions: no state, no latency.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int MAX_WR    = 8;
  localparam int WIDX_W    = $clog2(MAX_WR);

  typedef struct packed {
    logic              hit;
    logic [WIDX_W-1:0] idx;
  } wr_match_t;

  // Highest set bit wins, so later ports override earlier ones on a shared address.
  function automatic wr_match_t wr_match_hi(input logic [MAX_WR-1:0] match);
    wr_match_t res;
    res = '0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (match[i]) begin
        res.hit = 1'b1;
        res.idx = WIDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard plus write-collision flag; one-cycle registered outputs.
// Never stalls: claims and writes are absorbed every cycle.
module regfile_scoreboard #(
  parameter  int NREGS = 32,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR-1:0]    wr_eff_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              claim_en_i,
  input  logic [AW-1:0]     claim_addr_i,
  output logic [NREGS-1:0]  busy_vec_o,
  output logic              wr_conflict_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             conflict_q, conflict_d;

  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_eff_i[w]) busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
    end
    // Applied after the clears: a new producer supersedes the one retiring now.
    if (claim_en_i) busy_d[claim_addr_i] = 1'b1;
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_en_i[i] && wr_en_i[j] &&
            (wr_addr_i[i*AW +: AW] == wr_addr_i[j*AW +: AW]) &&
            (wr_addr_i[i*AW +: AW] != '0))
          conflict_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy_vec_o    = busy_q;
  assign wr_conflict_o = conflict_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: combinational reads with optional same-cycle bypass, writes on clk edge.
// No handshake and never stalls; consumers stall on rd_busy_o from the busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                claim_en_i,
  input  logic [AW-1:0]       claim_addr_i,
  output logic [NREGS-1:0]    busy_vec_o,
  output logic                wr_conflict_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NWR-1:0]  wr_eff;
  logic            claim_eff;

  // Writes and claims to the hardwired zero register are dropped here, once.
  always_comb begin
    wr_eff = '0;
    for (int w = 0; w < NWR; w++) begin
      wr_eff[w] = wr_en_i[w] && !((ZERO_REG != 0) && (wr_addr_i[w*AW +: AW] == '0));
    end
  end

  assign claim_eff = claim_en_i && !((ZERO_REG != 0) && (claim_addr_i == '0));

  always_comb begin
    for (int r = 0; r < NREGS; r++) regs_d[r] = regs_q[r];
    for (int w = 0; w < NWR; w++) begin
      if (wr_eff[w]) regs_d[wr_addr_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  always_comb begin
    logic [AW-1:0]     addr;
    logic [MAX_WR-1:0] match;
    wr_match_t         fwd;
    logic [XLEN-1:0]   data;
    logic              busy;
    rd_data_o = '0;
    rd_busy_o = '0;
    addr      = '0;
    match     = '0;
    fwd       = '0;
    data      = '0;
    busy      = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      addr  = rd_addr_i[p*AW +: AW];
      match = '0;
      for (int w = 0; w < NWR; w++) begin
        match[w] = wr_eff[w] && (wr_addr_i[w*AW +: AW] == addr);
      end
      fwd  = wr_match_hi(match);
      data = regs_q[addr];
      busy = busy_vec_o[addr];
      if ((BYPASS != 0) && fwd.hit) begin
        busy = 1'b0;
        for (int w = 0; w < NWR; w++) begin
          if (int'(fwd.idx) == w) data = wr_data_i[w*XLEN +: XLEN];
        end
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end
      rd_data_o[p*XLEN +: XLEN] = data;
      rd_busy_o[p]              = busy;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .wr_en_i       (wr_en_i),
    .wr_eff_i      (wr_eff),
    .wr_addr_i     (wr_addr_i),
    .claim_en_i    (claim_eff),
    .claim_addr_i  (claim_addr_i),
    .busy_vec_o    (busy_vec_o),
    .wr_conflict_o (wr_conflict_o)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on/off) share stimulus and are compared
// against an array-based model of the register file and scoreboard.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic [NREGS-1:0]    bv_b, bv_n;
  logic                conf_b, conf_n;

  logic [XLEN-1:0] m_reg [NREGS];
  bit              m_busy [NREGS];
  bit              m_conf;

  int checks   = 0;
  int failures = 0;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk_i(clk), .reset_i(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .claim_en_i(claim_en),
    .claim_addr_i(claim_addr), .busy_vec_o(bv_b), .wr_conflict_o(conf_b));

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk_i(clk), .reset_i(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .claim_en_i(claim_en),
    .claim_addr_i(claim_addr), .busy_vec_o(bv_n), .wr_conflict_o(conf_n));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; rd_addr = '0;
  endtask

  task automatic set_wr(input int w, input int a, input logic [XLEN-1:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = AW'(a);
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // Checks current outputs against the model, then advances model and DUT by one edge.
  task automatic step();
    int a;
    logic [XLEN-1:0] exp_d;
    bit exp_bz, hit;
    logic [NREGS-1:0] exp_bv;
    #1;
    for (int p = 0; p < NRD; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      hit = 1'b0;
      exp_d = m_reg[a];
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && a != 0 && int'(wr_addr[w*AW +: AW]) == a) begin
          hit = 1'b1;
          exp_d = wr_data[w*XLEN +: XLEN];
        end
      end
      if (a == 0) exp_d = '0;
      exp_bz = (a != 0) && m_busy[a] && !hit;
      check($sformatf("rd_data_byp[%0d] a=%0d", p, a), 64'(rd_data_b[p*XLEN +: XLEN]), 64'(exp_d));
      check($sformatf("rd_busy_byp[%0d] a=%0d", p, a), 64'(rd_busy_b[p]), 64'(exp_bz));
      exp_d  = (a == 0) ? '0 : m_reg[a];
      exp_bz = (a != 0) && m_busy[a];
      check($sformatf("rd_data_nobyp[%0d] a=%0d", p, a), 64'(rd_data_n[p*XLEN +: XLEN]), 64'(exp_d));
      check($sformatf("rd_busy_nobyp[%0d] a=%0d", p, a), 64'(rd_busy_n[p]), 64'(exp_bz));
    end
    for (int r = 0; r < NREGS; r++) exp_bv[r] = m_busy[r];
    check("busy_vec_byp", 64'(bv_b), 64'(exp_bv));
    check("busy_vec_nobyp", 64'(bv_n), 64'(exp_bv));
    check("wr_conflict_byp", 64'(conf_b), 64'(m_conf));
    check("wr_conflict_nobyp", 64'(conf_n), 64'(m_conf));
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
      m_conf = 1'b0;
    end else begin
      m_conf = wr_en[0] && wr_en[1] && (wr_addr[0 +: AW] == wr_addr[AW +: AW]) && (wr_addr[0 +: AW] != 0);
      for (int w = 0; w < NWR; w++) begin
        a = int'(wr_addr[w*AW +: AW]);
        if (wr_en[w] && a != 0) begin
          m_reg[a] = wr_data[w*XLEN +: XLEN];
          m_busy[a] = 1'b0;
        end
      end
      if (claim_en && claim_addr != 0) m_busy[int'(claim_addr)] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    for (int r = 0; r < NREGS; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
    m_conf = 1'b0;
    @(negedge clk);
    idle();

    // Reset state across every address.
    for (int a = 0; a < NREGS / 2; a++) begin
      set_rd(0, a); set_rd(1, a + NREGS / 2);
      step();
    end

    // Same-cycle write/read of addr 5.
    idle(); set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 5);
    #1 check("bypass_same_cycle", 64'(rd_data_b[XLEN-1:0]), 64'hDEADBEEF);
    check("nobypass_same_cycle", 64'(rd_data_n[XLEN-1:0]), 64'h0);
    step();
    idle(); set_rd(0, 5); step();

    // Collision on addr 7: highest port wins, conflict pulses once.
    idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); step();
    idle(); set_rd(1, 7);
    #1 check("conflict_pulse", 64'(conf_b), 64'h1);
    check("collide_winner", 64'(rd_data_n[XLEN +: XLEN]), 64'h22);
    step();
    idle(); #1 check("conflict_clear", 64'(conf_b), 64'h0);
    step();

    // Zero register ignores write and claim.
    idle(); set_wr(0, 0, 32'hFFFF_FFFF); claim_en = 1'b1; claim_addr = '0; set_rd(0, 0); step();
    idle(); set_rd(0, 0);
    #1 check("zero_busy_vec0", 64'(bv_b[0]), 64'h0);
    step();

    // Claim/write interaction on addr 3.
    idle(); claim_en = 1'b1; claim_addr = 5'd3; step();
    idle(); set_rd(0, 3);
    #1 check("claim_rd_busy", 64'(rd_busy_b[0]), 64'h1);
    step();
    idle(); set_wr(1, 3, 32'h3333); claim_en = 1'b1; claim_addr = 5'd3; step();
    idle(); set_rd(0, 3);
    #1 check("claim_beats_write", 64'(bv_b[3]), 64'h1);
    step();
    idle(); set_wr(1, 3, 32'h4444); set_rd(0, 3); step();
    idle(); set_rd(0, 3);
    #1 check("write_clears_busy", 64'(bv_b[3]), 64'h0);
    step();

    // Reset beats a simultaneous write and claim.
    idle(); set_wr(0, 9, 32'h9999); claim_en = 1'b1; claim_addr = 5'd9; step();
    idle(); set_wr(0, 9, 32'hABCD); claim_en = 1'b1; claim_addr = 5'd9; reset = 1'b1; step();
    idle(); set_rd(0, 9);
    #1 check("reset_clears_reg9", 64'(rd_data_n[XLEN-1:0]), 64'h0);
    check("reset_clears_busy", 64'(bv_b), 64'h0);
    step();

    // Random traffic, narrow address range to provoke collisions and bypasses.
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset = ($urandom_range(0, 59) == 0);
      for (int w = 0; w < NWR; w++) begin
        if ($urandom_range(0, 2) != 0)
          set_wr(w, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1), $urandom);
      end
      claim_en = ($urandom_range(0, 1) != 0);
      claim_addr = AW'($urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
